fc1_xnor_popcount: RTL and testbench

- Binary fully-connected stage directly downstream of the second pooling layer.
- On `start`, snapshots the 20x12x12 pooled binary feature map (2880 bits).
- For each of NEURONS output neurons, streams in weight words over a valid/ready handshake and accumulates XNOR-popcount against the snapshot.
- Emits one result per neuron: popcount sum plus thresholded activation bit, over a valid/ready handshake to the next layer.

---
 rtl/fc1_xnor_popcount.sv | 210 +++++++++++++++++++++
 tb/tb_fc1_xnor_popcount.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc1_xnor_popcount.sv
// fc1_xnor_popcount
// Binary fully-connected stage that sits after the second pooling layer.
// A start pulse taken in IDLE snapshots the pooled binary feature map. For
// each output neuron the block then streams CHUNK-bit weight words and adds
// up the XNOR matches against the snapshot. Each neuron's result (popcount
// sum plus thresholded bit) is then offered to the next layer.
//
// Ports
//   clk, rst    clock and asynchronous active-high reset
//   start       begin an evaluation run (honoured only in IDLE)
//   fmaps_in    pooled binary maps [channel][row][col]
//   busy        high whenever the block is not IDLE
//   w_valid     weight word valid
//   w_ready     weight word accepted this cycle when w_valid is also high
//   w_data      weight bits; bit j pairs with flat index chunk*CHUNK + j
//   out_valid   neuron result valid (held until out_ready)
//   out_ready   consumer accepts the result
//   out_idx     neuron index of the offered result
//   out_sum     XNOR-popcount over all CHANNELS*DIM*DIM bits
//   out_bit     out_sum >= THRESH
//   done        one-cycle pulse after the last neuron's result is accepted
module fc1_xnor_popcount #(
  parameter int CHANNELS = 20,
  parameter int DIM      = 12,
  parameter int CHUNK    = 48,
  parameter int NEURONS  = 100,
  parameter int THRESH   = 1440,
  localparam int NBITS   = CHANNELS * DIM * DIM,
  localparam int NCHUNK  = NBITS / CHUNK,
  localparam int SUM_W   = $clog2(NBITS + 1),
  localparam int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int CHK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  localparam int PC_W    = $clog2(CHUNK + 1)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [0:CHANNELS-1][0:DIM-1][0:DIM-1]      fmaps_in,
  output logic                                       busy,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [CHUNK-1:0]                           w_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [IDX_W-1:0]                           out_idx,
  output logic [SUM_W-1:0]                           out_sum,
  output logic                                       out_bit,
  output logic                                       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  // Count of set bits in one weight-sized word.
  function automatic logic [PC_W-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int j = 0; j < CHUNK; j++) begin
      n = n + PC_W'(v[j]);
    end
    return n;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [NBITS-1:0]   snap_r;
  logic [NBITS-1:0]   fmap_flat_s;
  logic [CHK_W-1:0]   chunk_r;
  logic [IDX_W-1:0]   neuron_r;
  logic [SUM_W-1:0]   acc_r;
  logic [SUM_W-1:0]   acc_sum_s;
  logic [CHUNK-1:0]   snap_chunk_s;
  logic [PC_W-1:0]    match_cnt_s;
  logic               acc_hit_s;
  logic               start_take_s;
  logic               w_fire_s;
  logic               out_fire_s;
  logic               last_chunk_s;
  logic               last_neuron_s;
  logic [IDX_W-1:0]   out_idx_r;
  logic [SUM_W-1:0]   out_sum_r;
  logic               out_bit_r;
  logic               done_r;
  logic               busy_r;
  logic               w_ready_r;
  logic               out_valid_r;

  // Flatten the map so that flat index c*DIM*DIM + r*DIM + col sits at that bit position.
  always_comb begin
    fmap_flat_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int r = 0; r < DIM; r++) begin
        for (int col = 0; col < DIM; col++) begin
          fmap_flat_s[c*DIM*DIM + r*DIM + col] = fmaps_in[c][r][col];
        end
      end
    end
  end

  // Handshake strobes, current snapshot slice and running-sum update.
  always_comb begin
    start_take_s  = (state_r == S_IDLE) && start;
    w_fire_s      = (state_r == S_ACC) && w_valid;
    out_fire_s    = (state_r == S_EMIT) && out_ready;
    last_chunk_s  = (chunk_r == CHK_W'(NCHUNK - 1));
    last_neuron_s = (neuron_r == IDX_W'(NEURONS - 1));
    snap_chunk_s  = snap_r[int'(chunk_r) * CHUNK +: CHUNK];
    match_cnt_s   = popcount(~(w_data ^ snap_chunk_s));
    // Cannot overflow: the total is bounded by NBITS, which SUM_W holds.
    acc_sum_s     = acc_r + SUM_W'(match_cnt_s);
    acc_hit_s     = (int'(acc_sum_s) >= THRESH);
  end

  // Next-state decode for the IDLE -> ACC <-> EMIT sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_take_s) begin
          state_next_s = S_ACC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACC: begin
        if (w_fire_s && last_chunk_s) begin
          state_next_s = S_EMIT;
        end else begin
          state_next_s = S_ACC;
        end
      end
      S_EMIT: begin
        if (out_fire_s) begin
          state_next_s = last_neuron_s ? S_IDLE : S_ACC;
        end else begin
          state_next_s = S_EMIT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register plus the handshake flags, which are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      w_ready_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      busy_r      <= (state_next_s != S_IDLE);
      w_ready_r   <= (state_next_s == S_ACC);
      out_valid_r <= (state_next_s == S_EMIT);
    end
  end

  // Snapshot, counters, accumulator and the captured neuron result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r    <= '0;
      chunk_r   <= '0;
      neuron_r  <= '0;
      acc_r     <= '0;
      out_idx_r <= '0;
      out_sum_r <= '0;
      out_bit_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      // The done flag is high only in the cycle after the final result is taken.
      done_r <= out_fire_s && last_neuron_s;
      if (start_take_s) begin
        snap_r   <= fmap_flat_s;
        neuron_r <= '0;
        chunk_r  <= '0;
        acc_r    <= '0;
      end else if (w_fire_s) begin
        acc_r <= acc_sum_s;
        if (last_chunk_s) begin
          // Capture the total including this final word.
          out_sum_r <= acc_sum_s;
          out_bit_r <= acc_hit_s;
          out_idx_r <= neuron_r;
        end else begin
          chunk_r <= chunk_r + CHK_W'(1);
        end
      end else if (out_fire_s && !last_neuron_s) begin
        neuron_r <= neuron_r + IDX_W'(1);
        chunk_r  <= '0;
        acc_r    <= '0;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign busy      = busy_r;
  assign w_ready   = w_ready_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_sum   = out_sum_r;
  assign out_bit   = out_bit_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fc1_xnor_popcount.sv
// Self-checking bench for fc1_xnor_popcount: table-driven directed patterns
// with constant expectations, randomized runs against a per-index matching
// model, backpressure, start/fmaps noise and a mid-run reset.
module tb_fc1_xnor_popcount;

  localparam int CHANNELS = 20;
  localparam int DIM      = 12;
  localparam int CHUNK    = 48;
  localparam int NEURONS  = 3;
  localparam int THRESH   = 1440;
  localparam int NBITS    = CHANNELS * DIM * DIM;
  localparam int NCHUNK   = NBITS / CHUNK;
  localparam int SUM_W    = $clog2(NBITS + 1);
  localparam int IDX_W    = $clog2(NEURONS);

  localparam int FK_ONES = 0, FK_ZEROS = 1, FK_CHECKER = 2, FK_LAST = 3, FK_RAND = 4;
  localparam int WK_ONES = 0, WK_ZEROS = 1, WK_LZ1439 = 2, WK_LZ1440 = 3,
                 WK_LAST = 4, WK_FIRST = 5, WK_RAND = 6;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [0:CHANNELS-1][0:DIM-1][0:DIM-1] fmaps_in;
  logic busy;
  logic w_valid;
  logic w_ready;
  logic [CHUNK-1:0] w_data;
  logic out_valid;
  logic out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [SUM_W-1:0] out_sum;
  logic out_bit;
  logic done;

  always #5 clk = ~clk;

  fc1_xnor_popcount #(
    .CHANNELS(CHANNELS), .DIM(DIM), .CHUNK(CHUNK), .NEURONS(NEURONS), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fmaps_in(fmaps_in), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_sum(out_sum), .out_bit(out_bit), .done(done)
  );

  typedef struct {
    int fk;
    int wk;
    int exp_sum;
    int exp_bit;
    int gap;
    int stall;
    int noise;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  bit fm3 [CHANNELS][DIM][DIM];
  logic [CHUNK-1:0] wts [NEURONS][NCHUNK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic gen_fmap(input int kind);
    for (int i = 0; i < NBITS; i++) begin
      bit v;
      case (kind)
        FK_ONES:    v = 1'b1;
        FK_ZEROS:   v = 1'b0;
        FK_CHECKER: v = (i % 2 == 1);
        FK_LAST:    v = (i == NBITS - 1);
        default:    v = 1'($urandom_range(1));
      endcase
      fm3[i / (DIM*DIM)][(i / DIM) % DIM][i % DIM] = v;
    end
  endtask

  task automatic gen_w(input int kind, input int n);
    for (int i = 0; i < NBITS; i++) begin
      logic v;
      case (kind)
        WK_ONES:   v = 1'b1;
        WK_ZEROS:  v = 1'b0;
        WK_LZ1439: v = (i >= 1439);
        WK_LZ1440: v = (i >= 1440);
        WK_LAST:   v = (i == NBITS - 1);
        WK_FIRST:  v = (i == 0);
        default:   v = 1'($urandom_range(1));
      endcase
      wts[n][i / CHUNK][i % CHUNK] = v;
    end
  endtask

  task automatic apply_fmap();
    for (int c = 0; c < CHANNELS; c++)
      for (int r = 0; r < DIM; r++)
        for (int col = 0; col < DIM; col++)
          fmaps_in[c][r][col] = fm3[c][r][col];
  endtask

  // Reference: count positions where the map bit equals the weight bit.
  function automatic int ref_sum(input int n);
    int s = 0;
    for (int c = 0; c < CHANNELS; c++)
      for (int r = 0; r < DIM; r++)
        for (int col = 0; col < DIM; col++) begin
          int i = c*DIM*DIM + r*DIM + col;
          if (fm3[c][r][col] == wts[n][i / CHUNK][i % CHUNK]) s++;
        end
    return s;
  endfunction

  task automatic run_job(input bit use_tab, input int tab_sum, input int tab_bit,
                         input int gap, input int stall, input bit noise,
                         input int abort_n, input int abort_k);
    int exp_s;
    int exp_b;
    int k;
    int t;
    bit early;
    apply_fmap();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("w_ready_in_acc", w_ready, 1);
    for (int n = 0; n < NEURONS; n++) begin
      exp_s = use_tab ? tab_sum : ref_sum(n);
      exp_b = use_tab ? tab_bit : int'(exp_s >= THRESH);
      k = 0;
      t = 0;
      early = 1'b0;
      while (k < NCHUNK && t < 4000) begin
        if (n == abort_n && k == abort_k) begin
          rst = 1'b1;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_w_ready", w_ready, 0);
          chk("rst_out_valid", out_valid, 0);
          chk("rst_done", done, 0);
          chk("rst_out_sum", out_sum, 0);
          chk("rst_out_idx", out_idx, 0);
          w_valid = 1'b0;
          start = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          return;
        end
        if (out_valid) early = 1'b1;
        if (noise) begin
          start = ($urandom_range(9) == 0);
          fmaps_in[$urandom_range(CHANNELS-1)][$urandom_range(DIM-1)][$urandom_range(DIM-1)] ^= 1'b1;
        end
        if (gap > 0 && $urandom_range(99) < gap) begin
          w_valid = 1'b0;
        end else begin
          w_valid = 1'b1;
          w_data = wts[n][k];
          if (w_ready) k++;
        end
        @(negedge clk);
        t++;
      end
      w_valid = 1'b0;
      w_data = CHUNK'({$urandom(), $urandom()});
      chk("feed_chunks", k, NCHUNK);
      chk("no_early_valid", early, 0);
      // With no gaps, each of the NCHUNK ACC cycles takes a word and the result follows at once.
      if (gap == 0) chk("latency_cycles", t, NCHUNK);
      chk("out_valid", out_valid, 1);
      chk("w_ready_emit", w_ready, 0);
      chk("out_idx", out_idx, n);
      chk("out_sum", out_sum, exp_s);
      chk("out_bit", out_bit, exp_b);
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        w_valid = noise;
        if (noise) start = 1'($urandom_range(1));
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_w_ready", w_ready, 0);
        chk("hold_idx", out_idx, n);
        chk("hold_sum", out_sum, exp_s);
        chk("hold_bit", out_bit, exp_b);
      end
      w_valid = 1'b0;
      out_ready = 1'b1;
      start = noise;  // start at the accept edge must be ignored
      @(negedge clk);
      out_ready = 1'b0;
      start = 1'b0;
      chk("valid_drop", out_valid, 0);
      chk("done_pulse", done, (n == NEURONS - 1));
      chk("busy_after_accept", busy, (n != NEURONS - 1));
    end
    @(negedge clk);
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  vec_t tab [8];

  initial begin
    tab[0] = '{FK_ONES,    WK_ONES,   2880, 1, 0,  0, 0};
    tab[1] = '{FK_ONES,    WK_ZEROS,  0,    0, 0,  0, 0};
    tab[2] = '{FK_CHECKER, WK_ONES,   1440, 1, 0,  0, 0};
    tab[3] = '{FK_ZEROS,   WK_LZ1439, 1439, 0, 0,  1, 0};
    tab[4] = '{FK_ZEROS,   WK_LZ1440, 1440, 1, 0,  0, 0};
    tab[5] = '{FK_LAST,    WK_LAST,   2880, 1, 0,  0, 0};
    tab[6] = '{FK_LAST,    WK_FIRST,  2878, 1, 0,  0, 0};
    tab[7] = '{FK_CHECKER, WK_ONES,   1440, 1, 30, 5, 1};

    rst = 1'b1;
    start = 1'b0;
    w_valid = 1'b0;
    w_data = '0;
    out_ready = 1'b0;
    fmaps_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_w_ready", w_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_bit", out_bit, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      gen_fmap(tab[v].fk);
      for (int n = 0; n < NEURONS; n++) gen_w(tab[v].wk, n);
      run_job(1'b1, tab[v].exp_sum, tab[v].exp_bit, tab[v].gap, tab[v].stall,
              tab[v].noise != 0, -1, -1);
    end

    for (int j = 0; j < 4; j++) begin
      gen_fmap(FK_RAND);
      for (int n = 0; n < NEURONS; n++) gen_w(WK_RAND, n);
      run_job(1'b0, 0, 0, int'($urandom_range(40)), int'($urandom_range(5)), 1'b1, -1, -1);
    end

    // Abort at chunk 30 of neuron 1, then rerun the same data from scratch.
    gen_fmap(FK_RAND);
    for (int n = 0; n < NEURONS; n++) gen_w(WK_RAND, n);
    run_job(1'b0, 0, 0, 0, 0, 1'b0, 1, 30);
    chk("post_rst_idle", busy, 0);
    run_job(1'b0, 0, 0, 10, 2, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
